// File: rtl/mmu_ht_pkg.sv
// Shared types and helpers for the MMU hash-table walker and the table loader model.
// The entry layout, walker states and bucket hash are defined once here.
package mmu_ht_pkg;

  localparam int ENT_ASIDW = 10;
  localparam int ENT_VPNW  = 20;
  localparam int ENT_PPNW  = 20;

  typedef struct packed {
    logic                 v;
    logic [ENT_ASIDW-1:0] asid;
    logic [ENT_VPNW-1:0]  vpn;
    logic [ENT_PPNW-1:0]  ppn;
    logic [2:0]           rwx;
    logic [9:0]           rsvd;
  } ht_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    HASH,
    READ,
    CMP,
    DONE
  } walk_state_t;

  // Folds the top IDXW bits of the VPN onto the bottom IDXW bits and mixes in the ASID.
  function automatic logic [31:0] ht_hash(input logic [31:0] vpn,
                                          input logic [31:0] asid,
                                          input int          vpnw,
                                          input int          idxw);
    logic [31:0] idx_mask;
    logic [31:0] vpn_mask;
    logic [31:0] vpn_lo;
    logic [31:0] vpn_hi;
    idx_mask = (idxw >= 32) ? '1 : ((32'd1 << idxw) - 32'd1);
    vpn_mask = (vpnw >= 32) ? '1 : ((32'd1 << vpnw) - 32'd1);
    vpn_lo   = vpn & idx_mask;
    vpn_hi   = (vpn & vpn_mask) >> (vpnw - idxw);
    return (vpn_lo ^ vpn_hi ^ asid) & idx_mask;
  endfunction

  function automatic logic [31:0] ht_entry_addr(input logic [31:0] base,
                                                input logic [31:0] idx);
    return base + (idx << 3);
  endfunction

endpackage

// File: rtl/ht_match.sv
// Combinational comparison of a fetched hash-table entry against the lookup key.
// "stop" is high when the entry ends the probe chain (empty slot or hit).
module ht_match
  import mmu_ht_pkg::*;
#(
  parameter int ASIDW = 10,
  parameter int VPNW  = 20
) (
  input  logic                 ent_v,
  input  logic [ENT_ASIDW-1:0] ent_asid,
  input  logic [ENT_VPNW-1:0]  ent_vpn,
  input  logic [ASIDW-1:0]     asid,
  input  logic [VPNW-1:0]      vpn,
  output logic                 hit,
  output logic                 stop
);

  logic asid_eq;
  logic vpn_eq;

  assign asid_eq = (ent_asid == ENT_ASIDW'(asid));
  assign vpn_eq  = (ent_vpn == ENT_VPNW'(vpn));
  assign hit     = ent_v && asid_eq && vpn_eq;
  assign stop    = !ent_v || hit;

endmodule

// File: rtl/ht_walker.sv
// Hash-table page-walk engine: hashes (ASID, VPN) to a bucket and linearly
// probes 64-bit entries through a single-outstanding bus master port.
module ht_walker
  import mmu_ht_pkg::*;
#(
  parameter int VPNW      = 20,
  parameter int ASIDW     = 10,
  parameter int PPNW      = 20,
  parameter int IDXW      = 12,
  parameter int MAX_PROBE = 8,
  parameter int TMO       = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      base,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ASIDW-1:0] req_asid,
  input  logic [VPNW-1:0]  req_vpn,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic             rsp_berr,
  output logic [PPNW-1:0]  rsp_ppn,
  output logic [2:0]       rsp_rwx,
  output logic [3:0]       rsp_probes,
  output logic             m_cyc,
  output logic             m_stb,
  output logic             m_we,
  output logic [31:0]      m_adr,
  input  logic             m_ack,
  input  logic [63:0]      m_dat_i
);

  localparam int PW = $clog2(MAX_PROBE + 1);
  localparam int TW = $clog2(TMO + 1);

  walk_state_t state;
  walk_state_t next_state;

  logic [ASIDW-1:0] asid_q;
  logic [VPNW-1:0]  vpn_q;
  logic [IDXW-1:0]  idx_q;
  logic [PW-1:0]    probes_q;
  logic [TW-1:0]    tmo_cnt;

  logic                 ent_v;
  logic [ENT_ASIDW-1:0] ent_asid;
  logic [ENT_VPNW-1:0]  ent_vpn;
  logic [ENT_PPNW-1:0]  ent_ppn;
  logic [2:0]           ent_rwx;

  ht_entry_t rd_entry;
  logic      unused_rsvd;
  logic      ent_hit;
  logic      ent_stop;
  logic      tmo_last;
  logic      probe_last;

  assign rd_entry    = ht_entry_t'(m_dat_i);
  assign unused_rsvd = ^rd_entry.rsvd;
  assign tmo_last    = (tmo_cnt == TW'(TMO - 1));
  assign probe_last  = (probes_q == PW'(MAX_PROBE));
  assign m_we        = 1'b0;

  ht_match #(
    .ASIDW(ASIDW),
    .VPNW (VPNW)
  ) u_match (
    .ent_v   (ent_v),
    .ent_asid(ent_asid),
    .ent_vpn (ent_vpn),
    .asid    (asid_q),
    .vpn     (vpn_q),
    .hit     (ent_hit),
    .stop    (ent_stop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (req_valid) next_state = HASH;
      HASH: next_state = READ;
      READ: begin
        if (m_ack) begin
          next_state = CMP;
        end else if (tmo_last) begin
          next_state = DONE;
        end
      end
      CMP: begin
        if (ent_stop || probe_last) begin
          next_state = DONE;
        end else begin
          next_state = READ;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus strobes come straight from the state register so an async reset drops them at once.
  always_comb begin
    req_ready = 1'b0;
    m_cyc     = 1'b0;
    m_stb     = 1'b0;
    m_adr     = '0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: req_ready = 1'b1;
      READ: begin
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_adr = ht_entry_addr(base, 32'(idx_q));
      end
      DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asid_q   <= '0;
      vpn_q    <= '0;
      idx_q    <= '0;
      probes_q <= '0;
      tmo_cnt  <= '0;
      ent_v    <= 1'b0;
      ent_asid <= '0;
      ent_vpn  <= '0;
      ent_ppn  <= '0;
      ent_rwx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            asid_q   <= req_asid;
            vpn_q    <= req_vpn;
            probes_q <= '0;
          end
        end
        HASH: begin
          idx_q   <= IDXW'(ht_hash(32'(vpn_q), 32'(asid_q), VPNW, IDXW));
          tmo_cnt <= '0;
        end
        READ: begin
          if (m_ack) begin
            ent_v    <= rd_entry.v;
            ent_asid <= rd_entry.asid;
            ent_vpn  <= rd_entry.vpn;
            ent_ppn  <= rd_entry.ppn;
            ent_rwx  <= rd_entry.rwx;
            probes_q <= probes_q + PW'(1);
          end else if (!tmo_last) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        CMP: begin
          if (next_state == READ) begin
            idx_q   <= idx_q + IDXW'(1);
            tmo_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Result fields update only on the way into DONE and hold until the next lookup finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_hit    <= 1'b0;
      rsp_berr   <= 1'b0;
      rsp_ppn    <= '0;
      rsp_rwx    <= '0;
      rsp_probes <= '0;
    end else if (next_state == DONE && state == READ) begin
      rsp_hit    <= 1'b0;
      rsp_berr   <= 1'b1;
      rsp_ppn    <= '0;
      rsp_rwx    <= '0;
      rsp_probes <= 4'(probes_q);
    end else if (next_state == DONE && state == CMP) begin
      rsp_hit    <= ent_hit;
      rsp_berr   <= 1'b0;
      rsp_ppn    <= ent_hit ? PPNW'(ent_ppn) : '0;
      rsp_rwx    <= ent_hit ? ent_rwx : 3'b000;
      rsp_probes <= 4'(probes_q);
    end
  end

endmodule

// File: tb/tb_ht_walker.sv
// Scoreboarded bench for ht_walker: a table model predicts each walk's reads and
// result, a bus slave model serves the table, and a monitor compares DUT output.
module tb_ht_walker;

  localparam int VPNW      = 20;
  localparam int ASIDW     = 10;
  localparam int PPNW      = 20;
  localparam int IDXW      = 12;
  localparam int MAX_PROBE = 8;
  localparam int TMO       = 255;
  localparam int NENT      = 1 << IDXW;

  typedef struct {
    bit             hit;
    bit             berr;
    logic [19:0]    ppn;
    logic [2:0]     rwx;
    int             probes;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      base = 32'h8000_0000;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [ASIDW-1:0] req_asid = '0;
  logic [VPNW-1:0]  req_vpn = '0;
  logic             rsp_valid;
  logic             rsp_hit;
  logic             rsp_berr;
  logic [PPNW-1:0]  rsp_ppn;
  logic [2:0]       rsp_rwx;
  logic [3:0]       rsp_probes;
  logic             m_cyc;
  logic             m_stb;
  logic             m_we;
  logic [31:0]      m_adr;
  logic             m_ack;
  logic [63:0]      m_dat_i;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [NENT];
  int          slv_delay = 0;
  bit          slv_never = 1'b0;
  bit          stray_en = 1'b0;
  int          slv_cnt = 0;
  logic        stray = 1'b0;
  logic [31:0] slv_off;

  exp_t        exp_q [$];
  logic [31:0] adr_q [$];
  exp_t        mon_e;
  logic [31:0] mon_a;

  ht_walker #(
    .VPNW(VPNW), .ASIDW(ASIDW), .PPNW(PPNW), .IDXW(IDXW),
    .MAX_PROBE(MAX_PROBE), .TMO(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .base      (base),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_asid  (req_asid),
    .req_vpn   (req_vpn),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_berr  (rsp_berr),
    .rsp_ppn   (rsp_ppn),
    .rsp_rwx   (rsp_rwx),
    .rsp_probes(rsp_probes),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_ack     (m_ack),
    .m_dat_i   (m_dat_i)
  );

  always #5 clk = ~clk;

  // Slave: acks after slv_delay wait cycles of a continuous strobe; stray acks only while idle.
  assign slv_off = m_adr - base;
  assign m_ack   = m_stb ? (!slv_never && (slv_cnt >= slv_delay)) : stray;
  assign m_dat_i = m_stb ? mem[slv_off[IDXW+2:3]] : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(posedge clk) begin
    if (m_stb && !m_ack) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
    stray <= stray_en && ($urandom_range(0, 3) == 0);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic noteFail(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  function automatic int idx_of(input logic [9:0] asid, input logic [19:0] vpn);
    int v;
    v = int'(vpn);
    return ((v % NENT) ^ (v / 256) ^ int'(asid)) % NENT;
  endfunction

  function automatic logic [63:0] mkEntry(input bit v, input logic [9:0] a, input logic [19:0] vp,
                                          input logic [19:0] p, input logic [2:0] r);
    return {v, a, vp, p, r, 10'($urandom)};
  endfunction

  task automatic clearMem();
    for (int i = 0; i < NENT; i++) mem[i] = {1'b0, 31'($urandom), 32'($urandom)};
  endtask

  // Reference walk over the table array; records every address the DUT should read.
  task automatic modelWalk(input logic [9:0] asid, input logic [19:0] vpn, output exp_t e);
    int          idx;
    logic [63:0] w;
    e = '{hit: 1'b0, berr: 1'b0, ppn: '0, rwx: '0, probes: 0};
    idx = idx_of(asid, vpn);
    if (slv_never) begin
      e.berr = 1'b1;
      return;
    end
    for (int p = 1; p <= MAX_PROBE; p++) begin
      adr_q.push_back(base + 32'(idx * 8));
      w = mem[idx];
      e.probes = p;
      if (!w[63]) return;
      if (w[62:53] == asid && w[52:33] == vpn) begin
        e.hit = 1'b1;
        e.ppn = w[32:13];
        e.rwx = w[12:10];
        return;
      end
      idx = (idx + 1) % NENT;
    end
  endtask

  // Issues one lookup, keeps req_valid asserted into the walk, and checks timing.
  task automatic applyStimulus(input string tag, input logic [9:0] asid, input logic [19:0] vpn,
                               input int delay, input bit never);
    exp_t e;
    int   n;
    int   lat;
    int   cyc_cnt;
    int   exp_lat;
    int   exp_cyc;
    slv_delay = delay;
    slv_never = never;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      noteFail({tag, "_ready_wait"}, "req_ready never rose");
      return;
    end
    modelWalk(asid, vpn, e);
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_asid  = asid;
    req_vpn   = vpn;
    @(posedge clk);
    #1;
    req_asid = ~asid;
    req_vpn  = ~vpn;
    lat = 0;
    cyc_cnt = 0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 2) req_valid = 1'b0;
      if (m_cyc) cyc_cnt++;
      if (rsp_valid) break;
    end
    req_valid = 1'b0;
    if (!rsp_valid) begin
      noteFail({tag, "_rsp_wait"}, "no rsp_valid within 2000 cycles");
      exp_q.delete();
      adr_q.delete();
      return;
    end
    if (never) begin
      exp_lat = TMO + 2;
      exp_cyc = TMO;
    end else begin
      exp_lat = 4 + delay + (e.probes - 1) * (2 + delay);
      exp_cyc = e.probes * (delay + 1);
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_cyc_cycles"}, 64'(cyc_cnt), 64'(exp_cyc));
    checkOutput({tag, "_reads_left"}, 64'(adr_q.size()), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
    slv_never = 1'b0;
  endtask

  // Monitor: every acked read and every result is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_cyc) checkOutput("m_we", 64'(m_we), 64'd0);
      if (m_cyc && m_stb && m_ack) begin
        if (adr_q.size() == 0) begin
          noteFail("extra_read", $sformatf("unexpected read at 0x%0h", m_adr));
        end else begin
          mon_a = adr_q.pop_front();
          checkOutput("m_adr", 64'(m_adr), 64'(mon_a));
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          noteFail("unexpected_rsp", $sformatf("hit=%0d berr=%0d probes=%0d", rsp_hit, rsp_berr, rsp_probes));
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_hit", 64'(rsp_hit), 64'(mon_e.hit));
          checkOutput("rsp_berr", 64'(rsp_berr), 64'(mon_e.berr));
          checkOutput("rsp_probes", 64'(rsp_probes), 64'(mon_e.probes));
          if (mon_e.hit) begin
            checkOutput("rsp_ppn", 64'(rsp_ppn), 64'(mon_e.ppn));
            checkOutput("rsp_rwx", 64'(rsp_rwx), 64'(mon_e.rwx));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [9:0]  asid;
  logic [19:0] vpn;
  logic [9:0]  oa;
  logic [19:0] ovpn;
  int          idx;
  int          k;
  int          term;

  initial begin
    $display("[TB] ht_walker bench start");
    clearMem();
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_m_cyc", 64'(m_cyc), 64'd0);
    checkOutput("reset_m_stb", 64'(m_stb), 64'd0);
    checkOutput("reset_m_adr", 64'(m_adr), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_hit", 64'(rsp_hit), 64'd0);
    checkOutput("reset_rsp_probes", 64'(rsp_probes), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-probe hit with a zero-wait slave.
    asid = 10'd3;
    vpn  = 20'h12345;
    idx  = idx_of(asid, vpn);
    mem[idx] = mkEntry(1'b1, asid, vpn, 20'hABCDE, 3'd5);
    applyStimulus("single_hit", asid, vpn, 0, 1'b0);
    checkOutput("single_hit_ppn_hold", 64'(rsp_ppn), 64'h0ABCDE);
    checkOutput("single_hit_rwx_hold", 64'(rsp_rwx), 64'd5);

    // Collision chain: two valid slots of another ASID precede the match.
    clearMem();
    mem[idx]              = mkEntry(1'b1, asid ^ 10'd1, vpn, 20'h11111, 3'd1);
    mem[(idx + 1) % NENT] = mkEntry(1'b1, asid ^ 10'd2, vpn, 20'h22222, 3'd2);
    mem[(idx + 2) % NENT] = mkEntry(1'b1, asid, vpn, 20'h33333, 3'd7);
    applyStimulus("chain", asid, vpn, 1, 1'b0);
    checkOutput("chain_probes_hold", 64'(rsp_probes), 64'd3);

    // Empty slot terminates the chain even when its key bits would match.
    clearMem();
    mem[idx] = mkEntry(1'b0, asid, vpn, 20'h44444, 3'd3);
    applyStimulus("empty", asid, vpn, 2, 1'b0);

    // Probe limit: ten non-matching valid entries, only eight may be read.
    clearMem();
    for (int j = 0; j < 10; j++) mem[(idx + j) % NENT] = mkEntry(1'b1, asid, vpn ^ 20'(j + 1), 20'(j), 3'd0);
    applyStimulus("limit", asid, vpn, 0, 1'b0);
    checkOutput("limit_probes_hold", 64'(rsp_probes), 64'd8);

    // Wrap-around: bucket 0xFFF misses, bucket 0 holds the match.
    clearMem();
    base = 32'h0001_0000;
    asid = 10'h3F3;
    vpn  = 20'h00C00;
    mem[NENT - 1] = mkEntry(1'b1, asid ^ 10'h001, vpn, 20'h55555, 3'd1);
    mem[0]        = mkEntry(1'b1, asid, vpn, 20'h66666, 3'd6);
    applyStimulus("wrap", asid, vpn, 0, 1'b0);
    checkOutput("wrap_probes_hold", 64'(rsp_probes), 64'd2);

    // Timeout: slave never acks; the next lookup must still complete.
    applyStimulus("timeout", 10'd7, 20'h0BEEF, 0, 1'b1);
    checkOutput("timeout_berr_hold", 64'(rsp_berr), 64'd1);
    applyStimulus("after_timeout", asid, vpn, 1, 1'b0);

    // Reset in the middle of a READ.
    slv_never = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_asid  = asid;
    req_vpn   = vpn;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_m_cyc", 64'(m_cyc), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_m_cyc", 64'(m_cyc), 64'd0);
    checkOutput("mid_reset_m_stb", 64'(m_stb), 64'd0);
    checkOutput("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    slv_never = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);
    applyStimulus("after_reset", asid, vpn, 0, 1'b0);

    // Randomised tables, keys, bases and slave wait states, with stray idle acks.
    stray_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      asid = 10'($urandom);
      vpn  = 20'($urandom);
      base = $urandom & 32'hFFFF_FFF8;
      clearMem();
      idx  = idx_of(asid, vpn);
      k    = $urandom_range(0, 10);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          oa   = asid;
          ovpn = vpn ^ 20'($urandom_range(1, 1048575));
        end else begin
          oa   = asid ^ 10'($urandom_range(1, 1023));
          ovpn = ($urandom_range(0, 1) == 1) ? vpn : 20'($urandom);
        end
        mem[(idx + j) % NENT] = mkEntry(1'b1, oa, ovpn, 20'($urandom), 3'($urandom));
      end
      term = $urandom_range(0, 2);
      if (term == 0) mem[(idx + k) % NENT] = mkEntry(1'b1, asid, vpn, 20'($urandom), 3'($urandom));
      else if (term == 1) mem[(idx + k) % NENT] = mkEntry(1'b0, asid, vpn, 20'($urandom), 3'($urandom));
      else mem[(idx + k) % NENT] = mkEntry(1'b1, asid ^ 10'h200, vpn, 20'($urandom), 3'($urandom));
      applyStimulus($sformatf("rand%0d", t), asid, vpn, $urandom_range(0, 3), 1'b0);
    end
    stray_en = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("final_rsp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
